seg_agu_pipe: RTL and testbench
===============================

Name: seg_agu_pipe

Overview:
- Parametrised, pipelined segment:offset address generation unit for the 8086-style core.
- Holds the segment register file and forms the effective address: base + index + displacement, modulo 2^OFF_W.
- Forms the physical address: (segment << SEG_SHIFT) + EA, modulo 2^PA_W.
- Sits between the decode/EU request side and the bus interface unit, with valid/ready handshakes on both sides.

Parameters:
- OFF_W, 16, offset/EA and segment register width
- SEG_SHIFT, 4, left shift applied to segment before add
- PA_W, 20, physical address width
- NUM_SEG, 4, number of segment registers (0=ES, 1=CS, 2=SS, 3=DS)
- SEL_W, 2, width of segment select (clog2 NUM_SEG)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- seg_wr_en  in  1  segment register write strobe
- seg_wr_sel  in  SEL_W  segment register to write
- seg_wr_data  in  OFF_W  write data
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_seg_sel  in  SEL_W  segment to use (override already resolved upstream)
- in_base  in  OFF_W  base register value (BX/BP or IP)
- in_index  in  OFF_W  index register value (SI/DI)
- in_disp  in  OFF_W  sign-extended displacement
- in_use_base  in  1  include in_base in sum
- in_use_index  in  1  include in_index in sum
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_ea  out  OFF_W  effective address
- out_addr  out  PA_W  physical address

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_ea=0, out_addr=0, internal stage-1 valid=0.
- Reset values of segment registers: CS=16'hFFFF, ES/SS/DS=0.
- Stage 1 (on accept):
  - Capture EA = (use_base?base:0) + (use_index?index:0) + disp, truncated to OFF_W (wraps, no carry out).
  - Capture the selected segment value.
- Stage 2: phys = ({segment, SEG_SHIFT zeros}) + zero-extended EA, truncated to PA_W, registered into out_addr/out_ea; out_valid=1.
- Latency: accepted request appears on out_* exactly 2 cycles later when there is no backpressure. Throughput is 1 per cycle.
- Handshake:
  - Each stage advances when its successor is empty or draining this cycle.
  - in_ready = !s1_valid || !out_valid || out_ready.
  - out_* stable while out_valid && !out_ready.
  - in_ready depends on registered state and out_ready only; no combinational path from in_valid.
- Segment write forwarding: if seg_wr_en and seg_wr_sel==in_seg_sel in the accept cycle, stage 1 captures seg_wr_data. Requests already in stage 1/2 keep their captured segment.
- Out-of-range seg_wr_sel/in_seg_sel (>= NUM_SEG): write ignored; read returns 0.
- Simultaneous accept and drain in the same cycle: both happen; no bubble inserted.
- Reset mid-operation: in-flight requests are discarded, segment registers return to reset values, and out_valid drops immediately.

Optional Feature:
- Macro SEG_AGU_LIMIT_CHECK_EN.
- When defined:
  - Adds a per-segment limit register file, reset value all-ones, written by seg_lim_wr_en/seg_lim_wr_sel/seg_lim_wr_data (OFF_W).
  - Adds output out_fault (1 bit, reset 0), registered alongside out_addr.
  - out_fault=1 when the captured EA > the captured limit of the selected segment. Address is still produced.
  - Limit write forwarding follows the same rules as segment write forwarding.
- When undefined: no limit registers, no extra ports, zero added logic.

Test Plan:
- Reset then request seg_sel=CS, base=16'h0000, use_base=1, disp=0 -> 2 cycles later out_addr=20'hFFFF0, out_ea=16'h0000.
- DS=16'h1000, base=16'h1234, index=16'h0010, disp=16'hFFFE, both uses=1 -> out_ea=16'h1242, out_addr=20'h11242.
- SS=16'hFFFF, base=16'h0010, use_base=1, disp=0 -> out_addr=20'h00000 (PA_W wrap). base=16'hFFFF, disp=16'h0002 -> out_ea=16'h0001 (OFF_W wrap).
- Stream 4 back-to-back requests with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, out_* held stable, all 4 delivered in order with no loss or duplication once out_ready=1.
- Write ES=16'h2000 in the same cycle as a request using ES with base=16'h0005 -> out_addr=20'h20005. A request already in flight retains the old ES.
- Assert rst while 2 requests are in flight -> out_valid=0 immediately, no stale output after release, CS reads back 16'hFFFF.

Source files
------------

// File: rtl/seg_agu_pipe.sv
// seg_agu_pipe
// Two-stage segment:offset address generation unit for an 8086-style core.
// Holds the segment register file. Stage 1 forms EA = base + index + disp
// (mod 2^OFF_W) and captures the selected segment. Stage 2 forms
// phys = (segment << SEG_SHIFT) + EA (mod 2^PA_W).
//
// Optional feature macro: SEG_AGU_LIMIT_CHECK_EN
//   When defined, adds a per-segment limit register file and out_fault.
//   out_fault flags EA > limit of the selected segment; the address is
//   still produced.
//
// Ports:
//   clk, rst                         clock (rising edge), async active-high reset
//   seg_wr_en/sel/data               segment register write
//   in_valid/in_ready                request handshake
//   in_seg_sel                       segment used by the request
//   in_base/in_index/in_disp         address components
//   in_use_base/in_use_index         include base / index in the sum
//   out_valid/out_ready              result handshake
//   out_ea, out_addr                 effective and physical address
//   seg_lim_wr_en/sel/data           limit register write (macro only)
//   out_fault                        limit violation flag (macro only)

module seg_agu_pipe #(
    parameter int OFF_W     = 16,
    parameter int SEG_SHIFT = 4,
    parameter int PA_W      = 20,
    parameter int NUM_SEG   = 4,
    parameter int SEL_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seg_wr_en,
    input  logic [SEL_W-1:0] seg_wr_sel,
    input  logic [OFF_W-1:0] seg_wr_data,
`ifdef SEG_AGU_LIMIT_CHECK_EN
    input  logic             seg_lim_wr_en,
    input  logic [SEL_W-1:0] seg_lim_wr_sel,
    input  logic [OFF_W-1:0] seg_lim_wr_data,
    output logic             out_fault,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_seg_sel,
    input  logic [OFF_W-1:0] in_base,
    input  logic [OFF_W-1:0] in_index,
    input  logic [OFF_W-1:0] in_disp,
    input  logic             in_use_base,
    input  logic             in_use_index,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OFF_W-1:0] out_ea,
    output logic [PA_W-1:0]  out_addr
);

    // Sum width wide enough for the shifted segment and for PA_W.
    localparam int SUM_W = (OFF_W + SEG_SHIFT > PA_W) ? (OFF_W + SEG_SHIFT) : PA_W;

    logic [OFF_W-1:0] r_seg [NUM_SEG];

    logic             r_s1_valid;
    logic [OFF_W-1:0] r_s1_ea;
    logic [OFF_W-1:0] r_s1_seg;

    logic             r_out_valid;
    logic [OFF_W-1:0] r_out_ea;
    logic [PA_W-1:0]  r_out_addr;

    logic             w_s2_adv;
    logic             w_accept;
    logic [OFF_W-1:0] w_ea;
    logic [OFF_W-1:0] w_seg_rd;
    logic [SUM_W-1:0] w_phys;

    // Stage 2 can take new data when empty or draining this cycle;
    // stage 1 can take new data when empty or moving into stage 2.
    assign w_s2_adv = !r_out_valid || out_ready;
    assign in_ready = !r_s1_valid || w_s2_adv;
    assign w_accept = in_valid && in_ready;

    assign w_ea = (in_use_base  ? in_base  : '0)
                + (in_use_index ? in_index : '0)
                + in_disp;

    // Selected segment, with same-cycle write forwarded. Out-of-range
    // selects never match a register and read as zero.
    always_comb begin
        w_seg_rd = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            if (in_seg_sel == SEL_W'(i)) begin
                w_seg_rd = (seg_wr_en && (seg_wr_sel == in_seg_sel)) ? seg_wr_data : r_seg[i];
            end
        end
    end

    assign w_phys = (SUM_W'(r_s1_seg) << SEG_SHIFT) + SUM_W'(r_s1_ea);

    // Segment register file; CS (index 1) resets to all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                r_seg[i] <= (i == 1) ? {OFF_W{1'b1}} : {OFF_W{1'b0}};
            end
        end else if (seg_wr_en) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                if (seg_wr_sel == SEL_W'(i)) begin
                    r_seg[i] <= seg_wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_ea    <= '0;
            r_s1_seg   <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_ea  <= w_ea;
                r_s1_seg <= w_seg_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_ea    <= '0;
            r_out_addr  <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_ea   <= r_s1_ea;
                r_out_addr <= w_phys[PA_W-1:0];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_ea    = r_out_ea;
    assign out_addr  = r_out_addr;

`ifdef SEG_AGU_LIMIT_CHECK_EN
    logic [OFF_W-1:0] r_lim [NUM_SEG];
    logic [OFF_W-1:0] r_s1_lim;
    logic             r_out_fault;
    logic [OFF_W-1:0] w_lim_rd;

    always_comb begin
        w_lim_rd = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            if (in_seg_sel == SEL_W'(i)) begin
                w_lim_rd = (seg_lim_wr_en && (seg_lim_wr_sel == in_seg_sel)) ? seg_lim_wr_data : r_lim[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                r_lim[i] <= {OFF_W{1'b1}};
            end
        end else if (seg_lim_wr_en) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                if (seg_lim_wr_sel == SEL_W'(i)) begin
                    r_lim[i] <= seg_lim_wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_lim    <= '0;
            r_out_fault <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_lim <= w_lim_rd;
            end
            if (w_s2_adv && r_s1_valid) begin
                r_out_fault <= (r_s1_ea > r_s1_lim);
            end
        end
    end

    assign out_fault = r_out_fault;
`else
    logic w_unused;
    assign w_unused = w_accept;
`endif

endmodule

// File: tb/tb_seg_agu_pipe.sv
module tb_seg_agu_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seg_wr_en = 1'b0;
    logic [1:0]  seg_wr_sel = '0;
    logic [15:0] seg_wr_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_seg_sel = '0;
    logic [15:0] in_base = '0;
    logic [15:0] in_index = '0;
    logic [15:0] in_disp = '0;
    logic        in_use_base = 1'b0;
    logic        in_use_index = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_ea;
    logic [19:0] out_addr;
`ifdef SEG_AGU_LIMIT_CHECK_EN
    logic        seg_lim_wr_en = 1'b0;
    logic [1:0]  seg_lim_wr_sel = '0;
    logic [15:0] seg_lim_wr_data = '0;
    logic        out_fault;
`endif

    localparam logic [1:0] ES = 2'd0, CS = 2'd1, SS = 2'd2, DS = 2'd3;

    seg_agu_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .seg_wr_en    (seg_wr_en),
        .seg_wr_sel   (seg_wr_sel),
        .seg_wr_data  (seg_wr_data),
`ifdef SEG_AGU_LIMIT_CHECK_EN
        .seg_lim_wr_en   (seg_lim_wr_en),
        .seg_lim_wr_sel  (seg_lim_wr_sel),
        .seg_lim_wr_data (seg_lim_wr_data),
        .out_fault       (out_fault),
`endif
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_seg_sel   (in_seg_sel),
        .in_base      (in_base),
        .in_index     (in_index),
        .in_disp      (in_disp),
        .in_use_base  (in_use_base),
        .in_use_index (in_use_index),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ea       (out_ea),
        .out_addr     (out_addr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [35:0] sb[$];          // {ea, addr}

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic fail_timeout(input string nm);
        n_chk++;
        $display("FAIL %s: timed out waiting, got no event expected one", nm);
    endtask

    // Monitor: pops the scoreboard on each output transfer and checks
    // that a stalled output does not change.
    logic        held = 1'b0;
    logic [35:0] held_val;
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {28'd0, out_ea, out_addr} >> 4, {28'd0, held_val} >> 4);
                chk("hold_addr_lo", {28'd0, out_addr[3:0]}, {28'd0, held_val[3:0]});
            end
            held = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_out: got ea=%h addr=%h expected none", out_ea, out_addr);
                end else begin
                    logic [35:0] e;
                    e = sb.pop_front();
                    chk("out_ea", {16'd0, out_ea}, {16'd0, e[35:20]});
                    chk("out_addr", {12'd0, out_addr}, {12'd0, e[19:0]});
`ifdef SEG_AGU_LIMIT_CHECK_EN
                    chk("out_fault", {31'd0, out_fault}, 32'd0);
`endif
                end
            end else if (out_valid && !out_ready) begin
                held = 1'b1;
                held_val = {out_ea, out_addr};
            end
        end
    end

    // Issue one request starting just after a rising edge; returns just
    // after the edge on which it was accepted.
    task automatic send(input logic [1:0] sel, input logic [15:0] base, input logic [15:0] idx,
                        input logic [15:0] disp, input logic ub, input logic ui,
                        input logic [15:0] exp_ea, input logic [19:0] exp_addr,
                        input logic we = 1'b0, input logic [1:0] wsel = 2'd0,
                        input logic [15:0] wdata = 16'd0);
        int t;
        in_valid = 1'b1; in_seg_sel = sel; in_base = base; in_index = idx;
        in_disp = disp; in_use_base = ub; in_use_index = ui;
        seg_wr_en = we; seg_wr_sel = wsel; seg_wr_data = wdata;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) fail_timeout("send_accept");
        else sb.push_back({exp_ea, exp_addr});
        @(posedge clk); #1;
        in_valid = 1'b0;
        seg_wr_en = 1'b0;
    endtask

    task automatic seg_write(input logic [1:0] sel, input logic [15:0] data);
        seg_wr_en = 1'b1; seg_wr_sel = sel; seg_wr_data = data;
        @(posedge clk); #1;
        seg_wr_en = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) fail_timeout("drain");
        @(posedge clk); #1;
    endtask

    initial begin
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_ea", {16'd0, out_ea}, 32'd0);
        chk("rst_out_addr", {12'd0, out_addr}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #19 rst = 1'b0;
        @(posedge clk); #1;

        // CS reset value and two-cycle latency
        send(CS, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 20'hFFFF0);
        chk("lat_s1", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_s2", {31'd0, out_valid}, 32'd1);
        drain();

        // Full sum with OFF_W wrap inside the EA
        seg_write(DS, 16'h1000);
        send(DS, 16'h1234, 16'h0010, 16'hFFFE, 1'b1, 1'b1, 16'h1242, 20'h11242);
        // PA_W wrap and OFF_W wrap
        seg_write(SS, 16'hFFFF);
        send(SS, 16'h0010, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0010, 20'h00000);
        send(SS, 16'hFFFF, 16'h0000, 16'h0002, 1'b1, 1'b0, 16'h0001, 20'hFFFF1);
        // use flags gate the operands
        send(DS, 16'h1234, 16'h5555, 16'h0020, 1'b0, 1'b0, 16'h0020, 20'h10020);
        send(DS, 16'h9999, 16'h0100, 16'h0000, 1'b0, 1'b1, 16'h0100, 20'h10100);
        drain();

        // Backpressure: 4 back-to-back with out_ready low for 3 edges
        out_ready = 1'b0;
        fork
            begin
                send(DS, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 20'h10000);
                send(DS, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 20'h10001);
                send(DS, 16'h0002, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0002, 20'h10002);
                send(DS, 16'h0003, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0003, 20'h10003);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
                chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Segment write forwarding; earlier in-flight request keeps old ES
        send(ES, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0005, 20'h00005);
        send(ES, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0005, 20'h20005, 1'b1, ES, 16'h2000);
        send(ES, 16'h0010, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0010, 20'h20010);
        drain();

        // Reset with two requests in flight
        send(DS, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 20'h10001);
        send(DS, 16'h0002, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0002, 20'h10002);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_addr", {12'd0, out_addr}, 32'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("no_stale", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        send(CS, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 20'hFFFF0);
        send(ES, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0005, 20'h00005);
        send(DS, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h1234, 20'h01234);
        drain();

        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
